// File: rtl/vault_pkg.sv
// Shared constants and types for the vault passcode front end.
package vault_pkg;

   localparam int DIGITS    = 4;
   localparam int DIGIT_W   = 4;
   localparam int CODE_W    = DIGITS * DIGIT_W;
   localparam int MAX_DIGIT = 9;

   typedef logic [DIGIT_W-1:0] digit_t;
   typedef logic [CODE_W-1:0]  code_t;

   localparam code_t DEFAULT_CODE = 16'h1234;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for a raw button level plus a delay flop that
// turns the synchronised rising edge into a one-cycle pulse.
module sync_edge_detect (
   input  logic clk,
   input  logic RESETN,
   input  logic async_in,
   output logic rise_pulse
);

   // [0] and [1] form the synchroniser, [2] is the edge-detect delay
   logic [2:0] sync_q;
   logic [2:0] sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], async_in};
   end

   always_ff @(posedge clk or negedge RESETN) begin
      if (!RESETN) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rise_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/passcode_entry.sv
// Keypad digit buffer, enter-button edge strobe and stored-code compare,
// with re-programming of the stored code while the vault is unlocked.
module passcode_entry
   import vault_pkg::*;
(
   input  logic                         clk,
   input  logic                         RESETN,
   input  logic                         KEY_VALID,
   input  logic [DIGIT_W-1:0]           KEY_DIGIT,
   input  logic                         KEY_CLEAR,
   input  logic                         ENTER_BTN,
   input  logic                         SET_MODE,
   input  logic                         UNLOCKED,
   output logic                         ENTER,
   output logic                         MATCH,
   output logic                         CODE_SAVED,
   output logic [$clog2(DIGITS+1)-1:0]  DIGIT_COUNT
);

   localparam int CNT_W = $clog2(DIGITS + 1);

   logic             enter_evt;
   logic             full;
   logic             program_evt;
   logic             digit_ok;

   code_t            entry_q, entry_d;
   code_t            code_q, code_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             enter_q, enter_d;
   logic             match_q, match_d;
   logic             saved_q, saved_d;

   sync_edge_detect u_enter_sync (
      .clk        (clk),
      .RESETN     (RESETN),
      .async_in   (ENTER_BTN),
      .rise_pulse (enter_evt)
   );

   // A coincident clear empties the buffer first, so programming cannot happen.
   assign full        = (cnt_q == CNT_W'(DIGITS));
   assign program_evt = enter_evt & ~KEY_CLEAR & SET_MODE & UNLOCKED & full;
   assign digit_ok    = (KEY_DIGIT <= DIGIT_W'(MAX_DIGIT));

   always_comb begin
      entry_d = entry_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      enter_d = 1'b0;
      saved_d = 1'b0;
      match_d = match_q;

      if (enter_evt) begin
         if (program_evt) begin
            code_d  = entry_q;
            saved_d = 1'b1;
         end else begin
            enter_d = 1'b1;
            match_d = ~KEY_CLEAR & full & (entry_q == code_q);
         end
         entry_d = '0;
         cnt_d   = '0;
      end else if (KEY_CLEAR) begin
         entry_d = '0;
         cnt_d   = '0;
      end else if (KEY_VALID && digit_ok && !full) begin
         entry_d = (entry_q << DIGIT_W) | CODE_W'(KEY_DIGIT);
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge RESETN) begin
      if (!RESETN) begin
         entry_q <= '0;
         cnt_q   <= '0;
         code_q  <= DEFAULT_CODE;
         enter_q <= 1'b0;
         match_q <= 1'b0;
         saved_q <= 1'b0;
      end else begin
         entry_q <= entry_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         enter_q <= enter_d;
         match_q <= match_d;
         saved_q <= saved_d;
      end
   end

   assign ENTER       = enter_q;
   assign MATCH       = match_q;
   assign CODE_SAVED  = saved_q;
   assign DIGIT_COUNT = cnt_q;

endmodule

// File: tb/tb_passcode_entry.sv
// Self-checking bench for passcode_entry: directed scenarios plus a random
// mix of keys, clears and enters checked against a digit-queue model.
module tb_passcode_entry;
   import vault_pkg::*;

   logic                        clk;
   logic                        RESETN;
   logic                        KEY_VALID;
   logic [DIGIT_W-1:0]          KEY_DIGIT;
   logic                        KEY_CLEAR;
   logic                        ENTER_BTN;
   logic                        SET_MODE;
   logic                        UNLOCKED;
   logic                        ENTER;
   logic                        MATCH;
   logic                        CODE_SAVED;
   logic [$clog2(DIGITS+1)-1:0] DIGIT_COUNT;

   int checks = 0;
   int errors = 0;

   // Reference model: digits typed so far, stored code as a digit list.
   int digits[$];
   int stored[DIGITS];
   bit exp_match;

   passcode_entry dut (
      .clk         (clk),
      .RESETN      (RESETN),
      .KEY_VALID   (KEY_VALID),
      .KEY_DIGIT   (KEY_DIGIT),
      .KEY_CLEAR   (KEY_CLEAR),
      .ENTER_BTN   (ENTER_BTN),
      .SET_MODE    (SET_MODE),
      .UNLOCKED    (UNLOCKED),
      .ENTER       (ENTER),
      .MATCH       (MATCH),
      .CODE_SAVED  (CODE_SAVED),
      .DIGIT_COUNT (DIGIT_COUNT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      digits.delete();
      stored[0] = 1; stored[1] = 2; stored[2] = 3; stored[3] = 4;
      exp_match = 1'b0;
   endfunction

   function automatic void model_key(input int d);
      if (d <= 9 && digits.size() < DIGITS) digits.push_back(d);
   endfunction

   // Returns 1 when the enter programs the code, 0 for a verify.
   function automatic bit model_enter(input bit clr);
      bit prog;
      bit same;
      if (clr) digits.delete();
      prog = SET_MODE && UNLOCKED && (digits.size() == DIGITS);
      if (prog) begin
         for (int i = 0; i < DIGITS; i++) stored[i] = digits[i];
      end else begin
         same = (digits.size() == DIGITS);
         if (same) for (int i = 0; i < DIGITS; i++) if (digits[i] != stored[i]) same = 1'b0;
         exp_match = same;
      end
      digits.delete();
      return prog;
   endfunction

   task automatic key(input int d);
      KEY_VALID = 1'b1;
      KEY_DIGIT = DIGIT_W'(d);
      tick();
      KEY_VALID = 1'b0;
      model_key(d);
      checks++;
      if (DIGIT_COUNT !== DIGIT_W'(digits.size())) begin
         errors++;
         $display("FAIL key_count digit=%0d got=%0d exp=%0d", d, DIGIT_COUNT, digits.size());
      end
   endtask

   task automatic press_enter(input int hold, input bit clr, input bit kv, input int kd);
      bit prog;
      ENTER_BTN = 1'b1;
      tick();
      checks++;
      if (ENTER !== 1'b0) begin errors++; $display("FAIL enter_early1 got=%b exp=0", ENTER); end
      tick();
      checks++;
      if (ENTER !== 1'b0) begin errors++; $display("FAIL enter_early2 got=%b exp=0", ENTER); end
      KEY_CLEAR = clr;
      if (kv) begin KEY_VALID = 1'b1; KEY_DIGIT = DIGIT_W'(kd); end
      prog = model_enter(clr);
      tick();
      KEY_CLEAR = 1'b0;
      KEY_VALID = 1'b0;
      checks++;
      if (ENTER !== !prog || CODE_SAVED !== prog || MATCH !== exp_match || DIGIT_COUNT !== '0) begin
         errors++;
         $display("FAIL enter_eval got enter=%b saved=%b match=%b cnt=%0d exp enter=%b saved=%b match=%b cnt=0",
                  ENTER, CODE_SAVED, MATCH, DIGIT_COUNT, !prog, prog, exp_match);
      end
      for (int i = 3; i < hold + 3; i++) begin
         if (i == hold) ENTER_BTN = 1'b0;
         tick();
         checks++;
         if (ENTER !== 1'b0 || CODE_SAVED !== 1'b0 || MATCH !== exp_match) begin
            errors++;
            $display("FAIL enter_single got enter=%b saved=%b match=%b exp 0 0 %b",
                     ENTER, CODE_SAVED, MATCH, exp_match);
         end
      end
   endtask

   task automatic do_reset();
      #2 RESETN = 1'b0;
      #1;
      model_reset();
      checks++;
      if (ENTER !== 1'b0 || MATCH !== 1'b0 || CODE_SAVED !== 1'b0 || DIGIT_COUNT !== '0) begin
         errors++;
         $display("FAIL reset_async got enter=%b match=%b saved=%b cnt=%0d exp all 0",
                  ENTER, MATCH, CODE_SAVED, DIGIT_COUNT);
      end
      tick();
      tick();
      #3 RESETN = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      RESETN = 1'b0; KEY_VALID = 0; KEY_DIGIT = 0; KEY_CLEAR = 0;
      ENTER_BTN = 0; SET_MODE = 0; UNLOCKED = 0;
      model_reset();
      tick();
      tick();
      #3 RESETN = 1'b1;
      tick();
      checks++;
      if (ENTER !== 1'b0 || MATCH !== 1'b0 || CODE_SAVED !== 1'b0 || DIGIT_COUNT !== '0) begin
         errors++;
         $display("FAIL reset_state got enter=%b match=%b saved=%b cnt=%0d exp all 0",
                  ENTER, MATCH, CODE_SAVED, DIGIT_COUNT);
      end
   endtask

   task automatic test_match_default();
      key(1); key(2); key(3); key(4);
      press_enter(10, 0, 0, 0);
   endtask

   task automatic test_mismatch_partial();
      key(1); key(2); key(3); key(5);
      press_enter(3, 0, 0, 0);
      key(1); key(2); key(3);
      press_enter(3, 0, 0, 0);
   endtask

   task automatic test_saturate_invalid();
      key(1); key(2); key(10); key(3); key(4); key(7); key(15);
      press_enter(3, 0, 0, 0);
   endtask

   task automatic test_program_verify();
      UNLOCKED = 1'b1; SET_MODE = 1'b1;
      key(9); key(8); key(7); key(6);
      press_enter(3, 0, 0, 0);
      SET_MODE = 1'b0; UNLOCKED = 1'b0;
      key(9); key(8); key(7); key(6);
      press_enter(3, 0, 0, 0);
      key(1); key(2); key(3); key(4);
      press_enter(3, 0, 0, 0);
   endtask

   task automatic test_same_cycle();
      for (int i = 0; i < DIGITS; i++) key(stored[i]);
      press_enter(3, 1, 0, 0);
      for (int i = 0; i < DIGITS - 1; i++) key(stored[i]);
      press_enter(3, 0, 1, stored[DIGITS-1]);
      SET_MODE = 1'b1; UNLOCKED = 1'b0;
      for (int i = 0; i < DIGITS; i++) key(stored[i]);
      press_enter(3, 0, 0, 0);
      SET_MODE = 1'b0;
   endtask

   task automatic test_reset_mid_entry();
      key(5); key(6);
      do_reset();
      key(1); key(2); key(3); key(4);
      press_enter(3, 0, 0, 0);
      UNLOCKED = 1'b1; SET_MODE = 1'b1;
      key(9); key(8); key(7); key(6);
      press_enter(3, 0, 0, 0);
      SET_MODE = 1'b0; UNLOCKED = 1'b0;
      do_reset();
      key(1); key(2); key(3); key(4);
      press_enter(3, 0, 0, 0);
   endtask

   task automatic test_random();
      int r;
      bit clr;
      bit kv;
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 4) begin
            key($urandom_range(0, 11));
         end else if (r == 5) begin
            KEY_CLEAR = 1'b1;
            tick();
            KEY_CLEAR = 1'b0;
            digits.delete();
            checks++;
            if (DIGIT_COUNT !== '0) begin
               errors++;
               $display("FAIL clear_count got=%0d exp=0", DIGIT_COUNT);
            end
         end else if (r == 6) begin
            for (int i = 0; i < DIGITS; i++) key(stored[i]);
         end else begin
            SET_MODE = 1'($urandom_range(0, 1));
            UNLOCKED = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 7) == 0);
            kv  = !clr && ($urandom_range(0, 7) == 0);
            press_enter($urandom_range(3, 6), clr, kv, $urandom_range(0, 9));
            SET_MODE = 1'b0;
            UNLOCKED = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_match_default();
      test_mismatch_partial();
      test_saturate_invalid();
      test_program_verify();
      test_same_cycle();
      test_reset_mid_entry();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
